wb_stream_writer_ctrl: RTL and testbench

WB_STREAM_WRITER_CTRL -- requirements
Module: wb_stream_writer_ctrl

---
 rtl/wb_stream_writer_ctrl_if.sv | 29 ++
 rtl/wb_stream_writer_ctrl.sv | 126 ++++++++++++
 tb/tb_wb_stream_writer_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_writer_ctrl_if.sv
// Wishbone bus bundle for the stream writer controller. The controller
// is a burst-reading master; the slave modport is what a memory model
// or interconnect sees.
interface wb_stream_writer_ctrl_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  logic [WB_AW-1:0]   adr_o;
  logic [WB_DW-1:0]   dat_o;
  logic [WB_DW/8-1:0] sel_o;
  logic               we_o;
  logic               cyc_o;
  logic               stb_o;
  logic [2:0]         cti_o;
  logic [1:0]         bte_o;
  logic [WB_DW-1:0]   dat_i;
  logic               ack_i;
  logic               err_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// Stream writer controller: walks a circular memory buffer with
// incrementing Wishbone read bursts and pushes every returned word into
// a downstream FIFO. A burst only starts when the FIFO has room for all
// of it, and bursts are cut short at the end of the buffer.
module wb_stream_writer_ctrl #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_stream_writer_ctrl_if.master wbm,
  output logic [WB_DW-1:0]      fifo_d,
  output logic                  fifo_wr,
  input  logic [FIFO_AW:0]      fifo_cnt,
  input  logic                  enable,
  output logic                  busy,
  output logic                  err,
  output logic [WB_DW-1:0]      tx_cnt,
  input  logic [WB_AW-1:0]      start_adr,
  input  logic [WB_AW-1:0]      buf_size,
  input  logic [WB_AW-1:0]      burst_size
);

  localparam logic [WB_AW-1:0] FIFO_DEPTH = WB_AW'(2**FIFO_AW);
  localparam logic [WB_AW-1:0] MAX_BURST  = WB_AW'(MAX_BURST_LEN);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WB_AW-1:0] burst_cnt;
  logic [WB_AW-1:0] room;
  logic [WB_DW-1:0] last_idx;
  logic             active;
  logic             buf_end;
  logic             burst_end;
  logic             last_beat;
  logic             burst_ok;
  logic             beat_ack;
  logic             beat_err;

  // Room is only consulted while armed; a burst is never started unless
  // every word it will return already has a FIFO slot waiting for it.
  assign room      = FIFO_DEPTH - WB_AW'(fifo_cnt);
  assign burst_ok  = (burst_size != '0) && (burst_size <= MAX_BURST) &&
                     (room >= burst_size);

  assign last_idx  = WB_DW'(buf_size >> 2) - WB_DW'(1);
  assign buf_end   = (tx_cnt == last_idx);
  assign burst_end = (burst_cnt == burst_size - WB_AW'(1));
  assign last_beat = burst_end | buf_end;

  // An error terminates the cycle and suppresses the FIFO write even if
  // a misbehaving slave raises ack alongside it.
  assign active    = (state == ACTIVE);
  assign beat_err  = active & wbm.err_i;
  assign beat_ack  = active & wbm.ack_i & ~wbm.err_i;

  assign fifo_wr   = beat_ack;
  assign fifo_d    = wbm.dat_i;
  assign busy      = (state != IDLE);

  assign wbm.adr_o = start_adr + WB_AW'({tx_cnt, 2'b00});
  assign wbm.dat_o = '0;
  assign wbm.sel_o = '1;
  assign wbm.we_o  = 1'b0;
  assign wbm.bte_o = 2'b00;
  assign wbm.cyc_o = active;
  assign wbm.stb_o = active;
  assign wbm.cti_o = active ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

  // State register; reset drops the bus cycle without waiting for a clock.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode: arm on enable, launch when the FIFO has room,
  // and leave the burst on its last beat or on a bus error.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ARMED;
      ARMED:   if (burst_ok) state_next = ACTIVE;
      ACTIVE: begin
        if (beat_err)                   state_next = IDLE;
        else if (beat_ack && last_beat) state_next = buf_end ? IDLE : ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer position, per-burst beat count and the sticky error flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_cnt    <= '0;
      burst_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            tx_cnt    <= '0;
            burst_cnt <= '0;
            err       <= 1'b0;
          end
        end
        ARMED: begin
          if (burst_ok) burst_cnt <= '0;
        end
        ACTIVE: begin
          if (beat_err) begin
            err <= 1'b1;
          end else if (beat_ack) begin
            tx_cnt    <= buf_end ? '0 : tx_cnt + WB_DW'(1);
            burst_cnt <= burst_cnt + WB_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Directed bench for the stream writer controller. A small slave model
// acks every beat while enabled, can inject an error on a chosen beat,
// and returns data derived from the address so FIFO data can be checked.
module tb_wb_stream_writer_ctrl;

  localparam int WB_AW         = 32;
  localparam int WB_DW         = 32;
  localparam int FIFO_AW       = 4;
  localparam int MAX_BURST_LEN = 16;
  localparam logic [31:0] PAT  = 32'hDA7A_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [WB_DW-1:0]  fifo_d;
  logic              fifo_wr;
  logic [FIFO_AW:0]  fifo_cnt;
  logic              enable;
  logic              busy;
  logic              err;
  logic [WB_DW-1:0]  tx_cnt;
  logic [WB_AW-1:0]  start_adr;
  logic [WB_AW-1:0]  buf_size;
  logic [WB_AW-1:0]  burst_size;

  int errors = 0;
  int checks = 0;

  wb_stream_writer_ctrl_if #(.WB_AW(WB_AW), .WB_DW(WB_DW)) wbm ();

  wb_stream_writer_ctrl #(
    .WB_AW(WB_AW), .WB_DW(WB_DW), .FIFO_AW(FIFO_AW), .MAX_BURST_LEN(MAX_BURST_LEN)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbm       (wbm),
    .fifo_d    (fifo_d),
    .fifo_wr   (fifo_wr),
    .fifo_cnt  (fifo_cnt),
    .enable    (enable),
    .busy      (busy),
    .err       (err),
    .tx_cnt    (tx_cnt),
    .start_adr (start_adr),
    .buf_size  (buf_size),
    .burst_size(burst_size)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave model
  logic ack_on, force_ack, force_err, err_hit;
  int   err_at  = -1;
  int   ack_seen = 0;

  assign err_hit   = (err_at >= 0) && (ack_seen == err_at);
  assign wbm.ack_i = (wbm.cyc_o && ack_on && !err_hit) || force_ack;
  assign wbm.err_i = (wbm.cyc_o && err_hit) || force_err;
  assign wbm.dat_i = wbm.adr_o ^ PAT;

  always @(posedge wb_clk_i)
    if (wbm.cyc_o && wbm.ack_i) ack_seen <= ack_seen + 1;

  // Beat log and FIFO write counter
  int          nbeats = 0;
  int          nwr    = 0;
  logic [31:0] log_adr [256];
  logic [2:0]  log_cti [256];
  logic [31:0] log_fd  [256];

  always @(negedge wb_clk_i) begin
    if (wbm.cyc_o && wbm.ack_i && nbeats < 256) begin
      log_adr[nbeats] <= wbm.adr_o;
      log_cti[nbeats] <= wbm.cti_o;
      log_fd[nbeats]  <= fifo_d;
      nbeats          <= nbeats + 1;
    end
    if (fifo_wr) nwr <= nwr + 1;
  end

  task automatic settle();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic start_run(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bu);
    start_adr  = sa;
    buf_size   = bs;
    burst_size = bu;
    settle();
    enable = 1'b1;
    settle();
    enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      settle();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; enable = 1'b0; fifo_cnt = '0; ack_on = 1'b1;
    force_ack = 1'b0; force_err = 1'b0;
    start_adr = '0; buf_size = 32'd64; burst_size = 32'd4;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if (tx_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_tx_cnt got %0d want 0", tx_cnt); end
    checks++; if ({wbm.cyc_o, wbm.stb_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_cyc_stb got %b want 00", {wbm.cyc_o, wbm.stb_o}); end
    checks++; if (wbm.cti_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_cti got %b want 000", wbm.cti_o); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_wr got %b want 0", fifo_wr); end
    checks++; if ({wbm.we_o, wbm.bte_o, wbm.sel_o, wbm.dat_o} !== {1'b0, 2'b00, 4'hF, 32'h0})
      begin errors++; $display("[TB] FAIL static_outputs got %h want %h", {wbm.we_o, wbm.bte_o, wbm.sel_o, wbm.dat_o}, {1'b0, 2'b00, 4'hF, 32'h0}); end
    wb_rst_i = 1'b0;
    settle();
  endtask

  task automatic test_basic();
    int b0, w0;
    bit ok;
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    b0 = nbeats; w0 = nwr;
    start_run(32'h1000, 32'd64, 32'd4);
    checks++; if ({busy, wbm.cyc_o} !== 2'b10) begin errors++; $display("[TB] FAIL armed_state busy,cyc got %b want 10", {busy, wbm.cyc_o}); end
    settle();
    checks++; if ({wbm.cyc_o, wbm.adr_o, wbm.cti_o} !== {1'b1, 32'h1000, 3'b010})
      begin errors++; $display("[TB] FAIL first_beat got %h want %h", {wbm.cyc_o, wbm.adr_o, wbm.cti_o}, {1'b1, 32'h1000, 3'b010}); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout busy got 1 want 0"); end
    checks++; if (nbeats - b0 !== 16) begin errors++; $display("[TB] FAIL basic_beats got %0d want 16", nbeats - b0); end
    checks++; if (nwr - w0 !== 16) begin errors++; $display("[TB] FAIL basic_fifo_wr got %0d want 16", nwr - w0); end
    for (int i = 0; i < 16; i++) begin
      exp_adr = 32'h1000 + 32'(4 * i);
      exp_cti = ((i % 4) == 3) ? 3'b111 : 3'b010;
      checks++;
      if ({log_adr[b0+i], log_cti[b0+i], log_fd[b0+i]} !== {exp_adr, exp_cti, exp_adr ^ PAT})
        begin errors++; $display("[TB] FAIL basic_beat%0d adr/cti/data got %h/%b/%h want %h/%b/%h", i,
          log_adr[b0+i], log_cti[b0+i], log_fd[b0+i], exp_adr, exp_cti, exp_adr ^ PAT); end
    end
    checks++; if ({tx_cnt, err} !== {32'd0, 1'b0}) begin errors++; $display("[TB] FAIL basic_end tx_cnt=%0d err=%b want 0,0", tx_cnt, err); end
  endtask

  task automatic test_room();
    int w0, ncyc;
    bit ok, found;
    w0 = nwr; ncyc = 0; found = 1'b0;
    fifo_cnt = 5'd13;
    start_run(32'h1000, 32'd64, 32'd4);
    for (int i = 0; i < 8; i++) begin
      settle();
      if (wbm.cyc_o) ncyc++;
    end
    checks++; if (ncyc !== 0) begin errors++; $display("[TB] FAIL room_stall cyc_cycles got %0d want 0", ncyc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL room_busy got %b want 1", busy); end
    fifo_cnt = 5'd12;
    for (int i = 0; i < 2; i++) begin
      settle();
      if (wbm.cyc_o) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL room_release cyc got 0 want 1"); end
    wait_idle(200, ok);
    checks++; if (!ok || (nwr - w0) !== 16) begin errors++; $display("[TB] FAIL room_complete done=%b fifo_wr=%0d want 1,16", ok, nwr - w0); end
    fifo_cnt = '0;
  endtask

  task automatic test_burst_limits();
    int b0, ncyc;
    bit ok;
    ncyc = 0;
    start_run(32'h4000, 32'd64, 32'd0);
    for (int i = 0; i < 5; i++) begin settle(); if (wbm.cyc_o) ncyc++; end
    checks++; if (ncyc !== 0) begin errors++; $display("[TB] FAIL burst_zero cyc_cycles got %0d want 0", ncyc); end
    burst_size = 32'd17;
    for (int i = 0; i < 5; i++) begin settle(); if (wbm.cyc_o) ncyc++; end
    checks++; if ({ncyc, busy} !== {32'd0, 1'b1}) begin errors++; $display("[TB] FAIL burst_too_long cyc_cycles=%0d busy=%b want 0,1", ncyc, busy); end
    b0 = nbeats;
    burst_size = 32'd16;
    wait_idle(200, ok);
    checks++; if (!ok || (nbeats - b0) !== 16) begin errors++; $display("[TB] FAIL burst_max done=%b beats=%0d want 1,16", ok, nbeats - b0); end
    checks++; if ({log_cti[b0+14], log_cti[b0+15], log_adr[b0+15]} !== {3'b010, 3'b111, 32'h403C})
      begin errors++; $display("[TB] FAIL burst_max_tail got %b %b %h want 010 111 0000403c", log_cti[b0+14], log_cti[b0+15], log_adr[b0+15]); end
  endtask

  task automatic test_short_buf();
    int b0;
    bit ok;
    logic [2:0] exp_cti [6] = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b111};
    b0 = nbeats;
    start_run(32'h2000, 32'd24, 32'd4);
    wait_idle(100, ok);
    checks++; if (!ok || (nbeats - b0) !== 6) begin errors++; $display("[TB] FAIL short_buf done=%b beats=%0d want 1,6", ok, nbeats - b0); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({log_adr[b0+i], log_cti[b0+i]} !== {32'h2000 + 32'(4 * i), exp_cti[i]})
        begin errors++; $display("[TB] FAIL short_beat%0d got %h/%b want %h/%b", i, log_adr[b0+i], log_cti[b0+i], 32'h2000 + 32'(4 * i), exp_cti[i]); end
    end
    checks++; if (tx_cnt !== 32'd0) begin errors++; $display("[TB] FAIL short_tx_cnt got %0d want 0", tx_cnt); end
  endtask

  task automatic test_single();
    int b0;
    bit ok;
    b0 = nbeats;
    start_run(32'h0300, 32'd8, 32'd1);
    wait_idle(50, ok);
    checks++; if (!ok || (nbeats - b0) !== 2) begin errors++; $display("[TB] FAIL single done=%b beats=%0d want 1,2", ok, nbeats - b0); end
    checks++; if ({log_adr[b0], log_cti[b0], log_adr[b0+1], log_cti[b0+1]} !== {32'h0300, 3'b111, 32'h0304, 3'b111})
      begin errors++; $display("[TB] FAIL single_beats got %h/%b %h/%b want 00000300/111 00000304/111",
        log_adr[b0], log_cti[b0], log_adr[b0+1], log_cti[b0+1]); end
  endtask

  task automatic test_error();
    int w0;
    bit ok, found;
    w0 = nwr; found = 1'b0;
    err_at = ack_seen + 2;
    start_run(32'h1000, 32'd64, 32'd4);
    for (int i = 0; i < 20; i++) begin
      if (wbm.err_i) begin found = 1'b1; break; end
      settle();
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL err_seen got 0 want 1"); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("[TB] FAIL err_fifo_wr got %b want 0", fifo_wr); end
    settle();
    err_at = -1;
    checks++; if ({wbm.cyc_o, busy, err} !== 3'b001) begin errors++; $display("[TB] FAIL err_after cyc,busy,err got %b want 001", {wbm.cyc_o, busy, err}); end
    checks++; if (tx_cnt !== 32'd2) begin errors++; $display("[TB] FAIL err_tx_cnt got %0d want 2", tx_cnt); end
    checks++; if (nwr - w0 !== 2) begin errors++; $display("[TB] FAIL err_fifo_writes got %0d want 2", nwr - w0); end
    start_run(32'h1000, 32'd64, 32'd4);
    checks++; if ({err, tx_cnt} !== {1'b0, 32'd0}) begin errors++; $display("[TB] FAIL err_clear err=%b tx_cnt=%0d want 0,0", err, tx_cnt); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL err_rerun_timeout busy got 1 want 0"); end
  endtask

  task automatic test_ignore();
    int b0;
    bit ok;
    force_err = 1'b1;
    settle();
    force_err = 1'b0;
    checks++; if ({busy, err} !== 2'b00) begin errors++; $display("[TB] FAIL idle_err_ignored busy,err got %b want 00", {busy, err}); end
    force_ack = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_fifo_wr got %b want 0", fifo_wr); end
    settle();
    force_ack = 1'b0;
    checks++; if (tx_cnt !== 32'd0) begin errors++; $display("[TB] FAIL idle_ack_tx_cnt got %0d want 0", tx_cnt); end
    fifo_cnt = 5'd16;
    start_run(32'h5000, 32'd8, 32'd4);
    force_ack = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("[TB] FAIL armed_ack_fifo_wr got %b want 0", fifo_wr); end
    settle();
    force_ack = 1'b0;
    start_run(32'h5000, 32'd8, 32'd4);
    checks++; if ({busy, wbm.cyc_o, tx_cnt} !== {1'b1, 1'b0, 32'd0}) begin errors++; $display("[TB] FAIL armed_ignore busy=%b cyc=%b tx_cnt=%0d want 1,0,0", busy, wbm.cyc_o, tx_cnt); end
    b0 = nbeats;
    fifo_cnt = '0;
    wait_idle(50, ok);
    checks++; if (!ok || (nbeats - b0) !== 2 || log_adr[b0] !== 32'h5000)
      begin errors++; $display("[TB] FAIL ignore_run done=%b beats=%0d adr=%h want 1,2,00005000", ok, nbeats - b0, log_adr[b0]); end
  endtask

  task automatic test_reset_mid();
    int b0, w0;
    bit ok;
    start_run(32'h1000, 32'd64, 32'd4);
    settle();
    settle();
    #1 wb_rst_i = 1'b1;
    #1;
    checks++; if ({wbm.cyc_o, wbm.stb_o, busy, fifo_wr, wbm.cti_o} !== 7'b0)
      begin errors++; $display("[TB] FAIL async_reset cyc,stb,busy,fifo_wr,cti got %b want 0000000", {wbm.cyc_o, wbm.stb_o, busy, fifo_wr, wbm.cti_o}); end
    checks++; if (tx_cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_tx_cnt got %0d want 0", tx_cnt); end
    w0 = nwr;
    for (int i = 0; i < 3; i++) settle();
    checks++; if (nwr - w0 !== 0) begin errors++; $display("[TB] FAIL reset_fifo_writes got %0d want 0", nwr - w0); end
    wb_rst_i = 1'b0;
    b0 = nbeats;
    start_run(32'h1000, 32'd64, 32'd4);
    checks++; if ({busy, tx_cnt} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL restart busy=%b tx_cnt=%0d want 1,0", busy, tx_cnt); end
    wait_idle(200, ok);
    checks++; if (!ok || (nbeats - b0) !== 16 || log_adr[b0] !== 32'h1000)
      begin errors++; $display("[TB] FAIL restart_run done=%b beats=%0d adr=%h want 1,16,00001000", ok, nbeats - b0, log_adr[b0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_room();
    test_burst_limits();
    test_short_buf();
    test_single();
    test_error();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
